alu_4bits_seq: RTL and testbench

//  Sequential signed ALU stage. Sits directly downstream of complement_to_2 and consumes its

---
 rtl/alu_4bits_seq.sv | 252 +++++++++++++++++++++++++
 tb/tb_alu_4bits_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_4bits_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_4bits_seq
//  Description : Sequential signed ALU stage. Add/sub complete in one step;
//                multiply (shift-add) and divide (restoring) iterate WIDTH
//                times on operand magnitudes, then a fix-up step applies the
//                signs. The result is held with a finish/ack handshake
//                against the upstream complement1_finish level.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_4bits_seq #(
  parameter int         WIDTH  = 4,
  parameter logic [3:0] OP_ADD = 4'b1010,
  parameter logic [3:0] OP_SUB = 4'b1011,
  parameter logic [3:0] OP_MUL = 4'b1100,
  parameter logic [3:0] OP_DIV = 4'b1101
) (
  input  logic                 clk,
  input  logic                 rst,                 // asynchronous, active-low
  input  logic [WIDTH-1:0]     first_nr,
  input  logic [WIDTH-1:0]     second_nr,
  input  logic [3:0]           operation,
  input  logic                 complement1_finish,
  output logic [2*WIDTH-1:0]   result,
  output logic [WIDTH-1:0]     remainder,
  output logic                 error,
  output logic                 alu_busy,
  output logic                 alu_finish
);

  // Iteration counter width; at least one bit so WIDTH=1 still elaborates.
  localparam int            CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDSUB = 3'd1,
    S_ITER   = 3'd2,
    S_FIX    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 r_start_prev;
  logic                 w_start;

  // Captured operation context
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [3:0]           r_op;
  logic [WIDTH-1:0]     r_mag_a;
  logic [WIDTH-1:0]     r_mag_b;
  logic                 r_sign_a;
  logic                 r_neg;
  logic                 r_err;
  logic [CW-1:0]        r_cnt;

  // Iterative datapath state
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_rem_w;
  logic [WIDTH-1:0]     r_quo;

  // Output registers
  logic [2*WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]     r_remainder;
  logic                 r_error;
  logic                 r_busy;
  logic                 r_finish;

  // Decode of the operation presented at capture time
  logic                 w_div_zero;
  logic                 w_legal;
  logic                 w_op_err;
  logic                 w_go_iter;
  logic [WIDTH-1:0]     w_mag_a_in;
  logic [WIDTH-1:0]     w_mag_b_in;

  // Add/sub operands, sign-extended to the result width
  logic [2*WIDTH-1:0]   w_sext_a;
  logic [2*WIDTH-1:0]   w_sext_b;

  // Multiply and divide step signals
  logic [2*WIDTH-1:0]   w_mcand_sh;
  logic                 w_div_bit;
  logic [WIDTH:0]       w_div_shift;
  logic [WIDTH:0]       w_div_trial;
  logic                 w_div_borrow;
  logic [WIDTH-1:0]     w_div_rem_nxt;

  assign w_start    = complement1_finish & ~r_start_prev;

  assign w_div_zero = (operation == OP_DIV) && (second_nr == '0);
  assign w_legal    = (operation == OP_ADD) || (operation == OP_SUB) ||
                      (operation == OP_MUL) || (operation == OP_DIV);
  assign w_op_err   = ~w_legal | w_div_zero;
  assign w_go_iter  = ((operation == OP_MUL) || (operation == OP_DIV)) && ~w_div_zero;

  assign w_mag_a_in = first_nr[WIDTH-1]  ? (WIDTH'(0) - first_nr)  : first_nr;
  assign w_mag_b_in = second_nr[WIDTH-1] ? (WIDTH'(0) - second_nr) : second_nr;

  assign w_sext_a   = {{WIDTH{r_a[WIDTH-1]}}, r_a};
  assign w_sext_b   = {{WIDTH{r_b[WIDTH-1]}}, r_b};

  // Multiplicand aligned to the multiplier bit being examined this step
  assign w_mcand_sh = {{WIDTH{1'b0}}, r_mag_a} << r_cnt;

  // Restoring division consumes dividend bits MSB first
  assign w_div_bit     = r_mag_a[c_cnt_last - r_cnt];
  assign w_div_shift   = {r_rem_w, w_div_bit};
  assign w_div_trial   = w_div_shift - {1'b0, r_mag_b};
  assign w_div_borrow  = w_div_trial[WIDTH];
  assign w_div_rem_nxt = w_div_borrow ? w_div_shift[WIDTH-1:0] : w_div_trial[WIDTH-1:0];

  assign result     = r_result;
  assign remainder  = r_remainder;
  assign error      = r_error;
  assign alu_busy   = r_busy;
  assign alu_finish = r_finish;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = w_go_iter ? S_ITER : S_ADDSUB;
        end
      end
      S_ADDSUB: w_state_nxt = S_DONE;
      S_ITER: begin
        if (r_cnt == c_cnt_last) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX:    w_state_nxt = S_DONE;
      S_DONE: begin
        if (!complement1_finish) begin
          w_state_nxt = S_IDLE;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and output registers, advanced by the current state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // start_prev resets high so a level already asserted cannot start an op
      r_start_prev <= 1'b1;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_mag_a      <= '0;
      r_mag_b      <= '0;
      r_sign_a     <= 1'b0;
      r_neg        <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_rem_w      <= '0;
      r_quo        <= '0;
      r_result     <= '0;
      r_remainder  <= '0;
      r_error      <= 1'b0;
      r_busy       <= 1'b0;
      r_finish     <= 1'b0;
    end else begin
      r_start_prev <= complement1_finish;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_a      <= first_nr;
            r_b      <= second_nr;
            r_op     <= operation;
            r_mag_a  <= w_mag_a_in;
            r_mag_b  <= w_mag_b_in;
            r_sign_a <= first_nr[WIDTH-1];
            r_neg    <= first_nr[WIDTH-1] ^ second_nr[WIDTH-1];
            r_err    <= w_op_err;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_rem_w  <= '0;
            r_quo    <= '0;
            r_error  <= 1'b0;
            r_busy   <= 1'b1;
          end
        end

        S_ADDSUB: begin
          r_busy      <= 1'b0;
          r_remainder <= '0;
          if (r_err) begin
            r_result <= '0;
            r_error  <= 1'b1;
          end else if (r_op == OP_SUB) begin
            r_result <= w_sext_a - w_sext_b;
          end else begin
            r_result <= w_sext_a + w_sext_b;
          end
        end

        S_ITER: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_op == OP_MUL) begin
            if (r_mag_b[r_cnt]) begin
              r_acc <= r_acc + w_mcand_sh;
            end
          end else begin
            r_rem_w <= w_div_rem_nxt;
            r_quo   <= {r_quo[WIDTH-2:0], ~w_div_borrow};
          end
        end

        S_FIX: begin
          r_busy <= 1'b0;
          if (r_op == OP_MUL) begin
            r_result    <= r_neg ? ((2*WIDTH)'(0) - r_acc) : r_acc;
            r_remainder <= '0;
          end else begin
            // Quotient truncates toward zero; remainder follows the dividend sign
            r_result    <= r_neg ? ((2*WIDTH)'(0) - {{WIDTH{1'b0}}, r_quo})
                                 : {{WIDTH{1'b0}}, r_quo};
            r_remainder <= r_sign_a ? (WIDTH'(0) - r_rem_w) : r_rem_w;
          end
        end

        S_DONE: begin
          // Finish is held while upstream keeps its level high; clears as we leave
          r_finish <= complement1_finish;
        end

        default: begin
          r_busy   <= 1'b0;
          r_finish <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_4bits_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_4bits_seq
//  Description : Scoreboard bench for alu_4bits_seq. Stimulus pushes the
//                hand-computed expected response; a monitor pops and compares
//                on each rising alu_finish, including capture-to-finish latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_4bits_seq;

  localparam logic [3:0] c_add = 4'b1010;
  localparam logic [3:0] c_sub = 4'b1011;
  localparam logic [3:0] c_mul = 4'b1100;
  localparam logic [3:0] c_div = 4'b1101;

  logic       clk;
  logic       rst;
  logic [3:0] first_nr;
  logic [3:0] second_nr;
  logic [3:0] operation;
  logic       complement1_finish;
  logic [7:0] result;
  logic [3:0] remainder;
  logic       error;
  logic       alu_busy;
  logic       alu_finish;

  typedef struct {
    logic [7:0] res;
    logic [3:0] rem;
    logic       err;
    int         cap;
    int         lat;
  } exp_t;

  exp_t sb_q[$];
  int   cyc       = 0;
  int   n_checks  = 0;
  int   n_errors  = 0;
  logic prev_fin  = 1'b0;

  alu_4bits_seq dut (
    .clk                (clk),
    .rst                (rst),
    .first_nr           (first_nr),
    .second_nr          (second_nr),
    .operation          (operation),
    .complement1_finish (complement1_finish),
    .result             (result),
    .remainder          (remainder),
    .error              (error),
    .alu_busy           (alu_busy),
    .alu_finish         (alu_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every rising alu_finish against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (alu_finish && !prev_fin) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_finish", 32'(alu_finish), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("result",    32'(result),    32'(e.res));
          chk("remainder", 32'(remainder), 32'(e.rem));
          chk("error",     32'(error),     32'(e.err));
          chk("busy_at_finish", 32'(alu_busy), 32'd0);
          chk("latency",   32'(cyc - e.cap), 32'(e.lat));
        end
      end
      prev_fin = alu_finish;
    end
  end

  // Issue one operation, wait for finish, hold the ack 'hold' cycles, then drop it
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                        input logic [7:0] er, input logic [3:0] erem, input logic ee,
                        input int elat, input int hold);
    exp_t e;
    int   k;
    @(negedge clk);
    first_nr           = a;
    second_nr          = b;
    operation          = op;
    complement1_finish = 1'b1;
    e.res = er; e.rem = erem; e.err = ee; e.cap = cyc + 1; e.lat = elat;
    sb_q.push_back(e);
    @(negedge clk);
    chk("busy_after_capture", 32'(alu_busy), 32'd1);
    k = 0;
    while (!alu_finish && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!alu_finish) begin
      chk("finish_timeout", 32'(alu_finish), 32'd1);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("finish_held", 32'(alu_finish), 32'd1);
      chk("no_restart_busy", 32'(alu_busy), 32'd0);
    end
    complement1_finish = 1'b0;
    @(negedge clk);
    chk("finish_drop", 32'(alu_finish), 32'd0);
  endtask

  initial begin
    rst                = 1'b0;
    first_nr           = '0;
    second_nr          = '0;
    operation          = '0;
    complement1_finish = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_result",    32'(result),     32'd0);
    chk("rst_remainder", 32'(remainder),  32'd0);
    chk("rst_error",     32'(error),      32'd0);
    chk("rst_busy",      32'(alu_busy),   32'd0);
    chk("rst_finish",    32'(alu_finish), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Add/sub
    run_op(4'b0111, 4'b1101, c_add, 8'h04, 4'h0, 1'b0, 2, 1);  //  7 + -3
    run_op(4'b1000, 4'b0111, c_sub, 8'hF1, 4'h0, 1'b0, 2, 1);  // -8 -  7
    run_op(4'b0110, 4'b1000, c_sub, 8'h0E, 4'h0, 1'b0, 2, 0);  //  6 - -8
    // Multiply
    run_op(4'b1000, 4'b0111, c_mul, 8'hC8, 4'h0, 1'b0, 6, 1);  // -8 *  7
    run_op(4'b1000, 4'b1000, c_mul, 8'h40, 4'h0, 1'b0, 6, 1);  // -8 * -8
    run_op(4'b0111, 4'b0111, c_mul, 8'h31, 4'h0, 1'b0, 6, 0);  //  7 *  7
    run_op(4'b1111, 4'b1111, c_mul, 8'h01, 4'h0, 1'b0, 6, 0);  // -1 * -1
    // Divide
    run_op(4'b1001, 4'b0010, c_div, 8'hFD, 4'hF, 1'b0, 6, 1);  // -7 /  2
    run_op(4'b1000, 4'b1111, c_div, 8'h08, 4'h0, 1'b0, 6, 0);  // -8 / -1
    run_op(4'b0111, 4'b1110, c_div, 8'hFD, 4'h1, 1'b0, 6, 0);  //  7 / -2
    run_op(4'b1001, 4'b0011, c_div, 8'hFE, 4'hF, 1'b0, 6, 0);  // -7 /  3
    // Errors, then a legal op clears the flag
    run_op(4'b0101, 4'b0000, c_div,   8'h00, 4'h0, 1'b1, 2, 0);
    run_op(4'b0101, 4'b0010, 4'b0011, 8'h00, 4'h0, 1'b1, 2, 0);
    run_op(4'b0011, 4'b0100, c_add,   8'h07, 4'h0, 1'b0, 2, 0);
    // Ack held for several cycles
    run_op(4'b0010, 4'b0011, c_mul, 8'h06, 4'h0, 1'b0, 6, 4);

    // Upstream level toggled during ITER is ignored: 3 * -5 = -15
    begin
      exp_t e;
      int   k;
      @(negedge clk);
      first_nr = 4'b0011; second_nr = 4'b1011; operation = c_mul;
      complement1_finish = 1'b1;
      e.res = 8'hF1; e.rem = 4'h0; e.err = 1'b0; e.cap = cyc + 1; e.lat = 6;
      sb_q.push_back(e);
      @(negedge clk);
      complement1_finish = 1'b0;
      @(negedge clk);
      complement1_finish = 1'b1;
      chk("result_held_during_iter", 32'(result), 32'h06);
      k = 0;
      while (!alu_finish && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("toggle_finish_seen", 32'(alu_finish), 32'd1);
      if (!alu_finish && sb_q.size() != 0) void'(sb_q.pop_front());
      complement1_finish = 1'b0;
      @(negedge clk);
      chk("toggle_finish_drop", 32'(alu_finish), 32'd0);
    end

    // Reset in the middle of a multiply aborts it
    @(negedge clk);
    first_nr = 4'b0011; second_nr = 4'b0101; operation = c_mul;
    complement1_finish = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_result",    32'(result),     32'd0);
    chk("abort_remainder", 32'(remainder),  32'd0);
    chk("abort_error",     32'(error),      32'd0);
    chk("abort_busy",      32'(alu_busy),   32'd0);
    chk("abort_finish",    32'(alu_finish), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_start_high_level_busy",   32'(alu_busy),   32'd0);
    chk("no_start_high_level_finish", 32'(alu_finish), 32'd0);
    complement1_finish = 1'b0;
    @(negedge clk);
    run_op(4'b0011, 4'b0101, c_mul, 8'h0F, 4'h0, 1'b0, 6, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d)", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
